// File: rtl/vec_mem_pkg.sv
// Shared types, default sizes and helpers for the vector load/store engine.
// Optional build macro VEC_STRIDE_EN is handled in the top module, not here.
package vec_mem_pkg;

  localparam int VMT_LANES      = 16;
  localparam int VMT_DATA_W     = 8;
  localparam int VMT_ADDR_W     = 12;
  localparam int VMT_BEAT_LANES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STORE,
    ST_LOAD,
    ST_DRAIN,
    ST_RESP
  } vmt_state_t;

  // Number of RAM beats needed to move one full vector.
  function automatic int nb_beats(input int lanes, input int beat_lanes);
    return lanes / beat_lanes;
  endfunction

  // Bit offset of beat `beat` inside a packed lane vector.
  function automatic int beat_lsb(input int beat, input int beat_lanes, input int data_w);
    return beat * beat_lanes * data_w;
  endfunction

endpackage

// File: rtl/vec_beat_addr_gen.sv
// Beat counter and per-beat RAM address generator for vector_mem_transfer.
// Address of beat k is base + k*stride, wrapping modulo 2^ADDR_W.
module vec_beat_addr_gen
  import vec_mem_pkg::*;
#(
  parameter int ADDR_W  = VMT_ADDR_W,
  parameter int NB      = 4,
  parameter int BEAT_BW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               advance,
  input  logic [ADDR_W-1:0]  base_in,
  input  logic [ADDR_W-1:0]  stride_in,
  output logic [BEAT_BW-1:0] beat,
  output logic               last,
  output logic [ADDR_W-1:0]  addr
);

  logic [ADDR_W-1:0]  base_reg;
  logic [ADDR_W-1:0]  stride_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [BEAT_BW-1:0] beat_reg;
  logic [BEAT_BW-1:0] beat_next;
  logic [ADDR_W-1:0]  addr_next;

  assign beat_next = beat_reg + BEAT_BW'(1);
  // Recomputed from base each beat rather than accumulated.
  assign addr_next = base_reg + ADDR_W'(beat_next) * stride_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_reg   <= '0;
      stride_reg <= '0;
      addr_reg   <= '0;
      beat_reg   <= '0;
    end else if (start) begin
      base_reg   <= base_in;
      stride_reg <= stride_in;
      addr_reg   <= base_in;
      beat_reg   <= '0;
    end else if (advance) begin
      beat_reg   <= beat_next;
      addr_reg   <= addr_next;
    end
  end

  assign beat = beat_reg;
  assign addr = addr_reg;
  assign last = (beat_reg == BEAT_BW'(NB - 1));

endmodule

// File: rtl/vector_mem_transfer.sv
// Vector load/store engine: moves one LANES-wide vector to/from RAM in NB beats.
// Define VEC_STRIDE_EN to add a req_stride port for strided beat addressing.
module vector_mem_transfer
  import vec_mem_pkg::*;
#(
  parameter int LANES      = VMT_LANES,
  parameter int DATA_W     = VMT_DATA_W,
  parameter int ADDR_W     = VMT_ADDR_W,
  parameter int BEAT_LANES = VMT_BEAT_LANES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_store,
  input  logic [ADDR_W-1:0]            req_base,
`ifdef VEC_STRIDE_EN
  input  logic [ADDR_W-1:0]            req_stride,
`endif
  input  logic [LANES*DATA_W-1:0]      req_data,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [BEAT_LANES*DATA_W-1:0] mem_wdata,
  output logic                         mem_we,
  output logic                         mem_re,
  input  logic [BEAT_LANES*DATA_W-1:0] mem_rdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_store,
  output logic [LANES*DATA_W-1:0]      rsp_data,
  output logic                         busy
);

  localparam int NB      = nb_beats(LANES, BEAT_LANES);
  localparam int BEAT_W  = BEAT_LANES * DATA_W;
  localparam int BEAT_BW = (NB > 1) ? $clog2(NB) : 1;

  vmt_state_t          state_reg;
  logic                store_reg;
  logic [LANES*DATA_W-1:0] data_reg;
  logic                pend_reg;
  logic [BEAT_BW-1:0]  pend_beat_reg;

  logic [BEAT_BW-1:0]  beat;
  logic [BEAT_BW-1:0]  beat_inc;
  logic                last_beat;
  logic                ag_start;
  logic                ag_advance;
  logic [ADDR_W-1:0]   stride_in;
  logic [BEAT_W-1:0]   store_beats [NB];

`ifdef VEC_STRIDE_EN
  assign stride_in = req_stride;
`else
  assign stride_in = ADDR_W'(BEAT_LANES);
`endif

  assign ag_start   = (state_reg == ST_IDLE) && req_valid;
  assign ag_advance = ((state_reg == ST_STORE) || (state_reg == ST_LOAD)) && !last_beat;
  assign beat_inc   = beat + BEAT_BW'(1);

  vec_beat_addr_gen #(
    .ADDR_W  (ADDR_W),
    .NB      (NB),
    .BEAT_BW (BEAT_BW)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .start     (ag_start),
    .advance   (ag_advance),
    .base_in   (req_base),
    .stride_in (stride_in),
    .beat      (beat),
    .last      (last_beat),
    .addr      (mem_addr)
  );

  // Store beats are sliced from the latched vector; load beats are captured per slice.
  for (genvar gi = 0; gi < NB; gi++) begin : g_beat
    logic [BEAT_W-1:0] slice_reg;

    assign store_beats[gi] = data_reg[beat_lsb(gi, BEAT_LANES, DATA_W) +: BEAT_W];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        slice_reg <= '0;
      end else if (pend_reg && (pend_beat_reg == BEAT_BW'(gi))) begin
        slice_reg <= mem_rdata;
      end
    end

    assign rsp_data[beat_lsb(gi, BEAT_LANES, DATA_W) +: BEAT_W] = slice_reg;
  end

  assign rsp_store = store_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
      mem_wdata     <= '0;
      rsp_valid     <= 1'b0;
      store_reg     <= 1'b0;
      data_reg      <= '0;
      pend_reg      <= 1'b0;
      pend_beat_reg <= '0;
    end else begin
      // A read issued this cycle returns data next cycle for that beat's slice.
      pend_reg      <= mem_re;
      pend_beat_reg <= beat;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            store_reg <= req_store;
            data_reg  <= req_data;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_store) begin
              state_reg <= ST_STORE;
              mem_we    <= 1'b1;
              mem_wdata <= req_data[BEAT_W-1:0];
            end else begin
              state_reg <= ST_LOAD;
              mem_re    <= 1'b1;
            end
          end
        end
        ST_STORE: begin
          if (last_beat) begin
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            state_reg <= ST_RESP;
          end else begin
            mem_wdata <= store_beats[beat_inc];
          end
        end
        ST_LOAD: begin
          if (last_beat) begin
            mem_re    <= 1'b0;
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          rsp_valid <= 1'b1;
          state_reg <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          mem_we    <= 1'b0;
          mem_re    <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
